logic_unit_pipe: RTL and testbench

- Parametrised WIDTH-bit bitwise logic unit with a registered output stage and a valid/ready handshake on both sides.
- Supports eight bitwise operations plus an accumulate mode, where operand A is replaced by an internal accumulator register.
- Produces registered result flags and a transaction counter.
- Successor to the fixed 8-bit OR gate; intended as the logic-op slice of the datapath library.

---
 rtl/logic_unit_pipe_if.sv | 32 +++
 rtl/logic_unit_pipe.sv | 97 +++++++++
 tb/tb_logic_unit_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for the pipelined bitwise logic unit.
// master drives operands and out_ready; slave is the logic unit itself.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] F;
    logic             out_valid;
    logic             out_ready;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    modport master (
        output A, B, op, acc_en, acc_clr, in_valid, out_ready,
        input  in_ready, F, out_valid, zero, ones, parity, acc, count
    );

    modport slave (
        input  A, B, op, acc_en, acc_clr, in_valid, out_ready,
        output in_ready, F, out_valid, zero, ones, parity, acc, count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with one registered output stage, result flags,
// an accumulator that can stand in for operand A, and an accepted-transaction counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    logic_unit_pipe_if.slave   bus
);
    logic [WIDTH-1:0] f_q, f_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // A clear that coincides with an accumulate uses zero as operand A.
    assign op_a = bus.acc_en ? (bus.acc_clr ? '0 : acc_q) : bus.A;

    always_comb begin
        result = '0;
        case (bus.op)
            3'b000:  result = op_a & bus.B;
            3'b001:  result = op_a | bus.B;
            3'b010:  result = op_a ^ bus.B;
            3'b011:  result = ~(op_a & bus.B);
            3'b100:  result = ~(op_a | bus.B);
            3'b101:  result = ~(op_a ^ bus.B);
            3'b110:  result = ~op_a;
            default: result = bus.B;
        endcase
    end

    always_comb begin
        f_d         = f_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        count_d     = count_q;
        acc_d       = acc_q;
        if (accept) begin
            f_d         = result;
            out_valid_d = 1'b1;
            zero_d      = (result == '0);
            ones_d      = &result;
            parity_d    = ^result;
            count_d     = count_q + CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && bus.acc_en) begin
            acc_d = result;
        end else if (bus.acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q         <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
        end else begin
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.F         = f_q;
    assign bus.out_valid = out_valid_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.parity    = parity_q;
    assign bus.acc       = acc_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe; a second instance with CNT_W=2
// exercises counter wrap.
module tb_logic_unit_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) bus ();
    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic en, input logic clr);
        bus.in_valid = v;
        bus.op       = op;
        bus.A        = a;
        bus.B        = b;
        bus.acc_en   = en;
        bus.acc_clr  = clr;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] f, input logic z,
                           input logic o, input logic p, input logic [7:0] cnt);
        chk({tag, ".F"},      32'(bus.F), 32'(f));
        chk({tag, ".valid"},  32'(bus.out_valid), 32'd1);
        chk({tag, ".zero"},   32'(bus.zero), 32'(z));
        chk({tag, ".ones"},   32'(bus.ones), 32'(o));
        chk({tag, ".parity"}, 32'(bus.parity), 32'(p));
        chk({tag, ".count"},  32'(bus.count), 32'(cnt));
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sweep_exp = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hA5};
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.op = 3'd0; bus2.A = 8'h00; bus2.B = 8'h00;
        bus2.acc_en = 1'b0; bus2.acc_clr = 1'b0; bus2.out_ready = 1'b1;

        #3;
        chk("rst.F",        32'(bus.F), 32'h0);
        chk("rst.valid",    32'(bus.out_valid), 32'h0);
        chk("rst.zero",     32'(bus.zero), 32'h0);
        chk("rst.ones",     32'(bus.ones), 32'h0);
        chk("rst.parity",   32'(bus.parity), 32'h0);
        chk("rst.acc",      32'(bus.acc), 32'h0);
        chk("rst.count",    32'(bus.count), 32'h0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'h1);
        #9 rst = 1'b0;

        // single OR
        drive(1'b1, 3'b001, 8'h0F, 8'hF0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk_out("or", 8'hFF, 1'b0, 1'b1, 1'b0, 8'd1);
        tick();
        chk("drain.valid", 32'(bus.out_valid), 32'h0);
        chk("drain.F",     32'(bus.F), 32'hFF);

        // back-to-back XOR
        drive(1'b1, 3'b010, 8'hAA, 8'h55, 1'b0, 1'b0);
        tick();
        chk_out("xor0", 8'hFF, 1'b0, 1'b1, 1'b0, 8'd2);
        chk("xor0.in_ready", 32'(bus.in_ready), 32'h1);
        drive(1'b1, 3'b010, 8'hFF, 8'hFF, 1'b0, 1'b0);
        tick();
        chk_out("xor1", 8'h00, 1'b1, 1'b0, 1'b0, 8'd3);
        chk("xor1.in_ready", 32'(bus.in_ready), 32'h1);
        drive(1'b1, 3'b010, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk_out("xor2", 8'h00, 1'b1, 1'b0, 1'b0, 8'd4);

        // backpressure: new operands waiting while the result is held
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 8'h12, 8'h30, 1'b0, 1'b0);
        #1;
        chk("bp.in_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp.hold", 8'h00, 1'b1, 1'b0, 1'b0, 8'd4);
            chk("bp.in_ready_hold", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk_out("bp.new", 8'h32, 1'b0, 1'b0, 1'b1, 8'd5);

        // accumulate chain
        drive(1'b1, 3'b001, 8'hEE, 8'h01, 1'b1, 1'b1);
        tick();
        chk("acc0.acc", 32'(bus.acc), 32'h01);
        chk("acc0.F",   32'(bus.F), 32'h01);
        drive(1'b1, 3'b001, 8'hEE, 8'h02, 1'b1, 1'b0);
        tick();
        chk("acc1.acc", 32'(bus.acc), 32'h03);
        chk("acc1.F",   32'(bus.F), 32'h03);
        drive(1'b1, 3'b001, 8'hEE, 8'h80, 1'b1, 1'b0);
        tick();
        chk("acc2.acc", 32'(bus.acc), 32'h83);
        chk("acc2.F",   32'(bus.F), 32'h83);
        drive(1'b1, 3'b010, 8'hEE, 8'h83, 1'b1, 1'b0);
        tick();
        chk("acc3.acc", 32'(bus.acc), 32'h00);
        chk_out("acc3", 8'h00, 1'b1, 1'b0, 1'b0, 8'd9);

        // clear without accept, while output is stalled
        drive(1'b1, 3'b111, 8'h00, 8'h5A, 1'b1, 1'b0);
        tick();
        chk("load.acc", 32'(bus.acc), 32'h5A);
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b111, 8'h00, 8'hFF, 1'b0, 1'b1);
        tick();
        chk("clr.acc",   32'(bus.acc), 32'h00);
        chk("clr.valid", 32'(bus.out_valid), 32'h1);
        chk("clr.F",     32'(bus.F), 32'h5A);
        chk("clr.count", 32'(bus.count), 32'd10);
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        // op sweep
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 8'hC3, 8'hA5, 1'b0, 1'b0);
            tick();
            chk($sformatf("sweep%0d.F", k), 32'(bus.F), 32'(sweep_exp[k]));
        end
        chk("sweep.count", 32'(bus.count), 32'd18);

        // asynchronous reset mid-operation
        drive(1'b1, 3'b111, 8'h00, 8'h5A, 1'b1, 1'b0);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre_rst.acc", 32'(bus.acc), 32'h5A);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid",    32'(bus.out_valid), 32'h0);
        chk("arst.F",        32'(bus.F), 32'h0);
        chk("arst.acc",      32'(bus.acc), 32'h0);
        chk("arst.count",    32'(bus.count), 32'h0);
        chk("arst.in_ready", 32'(bus.in_ready), 32'h1);
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b000, 8'hFF, 8'h0F, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk_out("post_rst", 8'h0F, 1'b0, 1'b0, 1'b0, 8'd1);

        // counter wrap on the CNT_W=2 instance
        bus2.in_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("wrap%0d.count", n), 32'(bus2.count), 32'(n % 4));
        end
        bus2.in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
